// File: rtl/bus_driver_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_driver_arbiter
//  Description : Fixed-priority datapath bus driver. Source 0 has the highest
//                priority. The LC-3 mapping is 0=MARMux, 1=PC, 2=ALU, 3=MDR.
//                Provides a registered bus copy, an optional hold-last-value
//                idle mode, and multi-driver contention detection with a
//                sticky flag and a saturating error counter.
//
//  Ports       : clk               - rising-edge clock
//                reset_n           - asynchronous active-low reset
//                src_data          - NSRC packed words, source i at [i*WIDTH +: WIDTH]
//                src_ena           - per-source drive request
//                clr_err           - synchronous clear of sticky flag and counter
//                bus_out           - combinational bus value (Z or last value when idle)
//                grant             - combinational one-hot grant, zero when idle
//                contention        - combinational, more than one request high
//                bus_q             - registered selected word
//                bus_q_valid       - registered "some source was granted"
//                grant_q           - registered grant
//                contention_sticky - latched contention flag
//                contention_cnt    - saturating count of contention cycles
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_driver_arbiter #(
    parameter int WIDTH     = 16,
    parameter int NSRC      = 4,
    parameter int HOLD_LAST = 0,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic [NSRC-1:0]         src_ena,
    input  logic                    clr_err,
    output logic [WIDTH-1:0]        bus_out,
    output logic [NSRC-1:0]         grant,
    output logic                    contention,
    output logic [WIDTH-1:0]        bus_q,
    output logic                    bus_q_valid,
    output logic [NSRC-1:0]         grant_q,
    output logic                    contention_sticky,
    output logic [CNT_W-1:0]        contention_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [NSRC-1:0]  w_grant;
    logic [WIDTH-1:0] w_sel;
    logic             w_any;
    logic             w_contention;

    logic [WIDTH-1:0] r_last_val;
    logic             r_bus_q_valid;
    logic [NSRC-1:0]  r_grant_q;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    // Priority encoder + mux. Scanning from the top down lets the lowest
    // enabled index overwrite any earlier hit, so source 0 always wins.
    always_comb begin
        w_grant = '0;
        w_sel   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_ena[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
                w_sel      = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_any = |src_ena;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_contention = |(src_ena & (src_ena - NSRC'(1)));

    // The registered bus copy and the hold-mode last value follow the same
    // load rule (load on any grant, otherwise hold), so one register serves both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_val    <= '0;
            r_bus_q_valid <= 1'b0;
            r_grant_q     <= '0;
        end else begin
            if (w_any) begin
                r_last_val <= w_sel;
            end
            r_bus_q_valid <= w_any;
            r_grant_q     <= w_grant;
        end
    end

    // Contention on the same clock as a clear takes precedence: the flag
    // stays set and the counter restarts at one rather than zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_contention) begin
                r_sticky <= 1'b1;
            end else if (clr_err) begin
                r_sticky <= 1'b0;
            end

            if (clr_err) begin
                r_cnt <= w_contention ? c_cnt_one : '0;
            end else if (w_contention && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    generate
        if (HOLD_LAST != 0) begin : g_hold_last
            // Reset clears the last value, so an idle bus reads zero during reset.
            assign bus_out = w_any ? w_sel : r_last_val;
        end else begin : g_tristate
            assign bus_out = w_any ? w_sel : {WIDTH{1'bz}};
        end
    endgenerate

    assign grant             = w_grant;
    assign contention        = w_contention;
    assign bus_q             = r_last_val;
    assign bus_q_valid       = r_bus_q_valid;
    assign grant_q           = r_grant_q;
    assign contention_sticky = r_sticky;
    assign contention_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_driver_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_driver_arbiter
//  Description : Self-checking bench for bus_driver_arbiter. Two instances
//                share the stimulus: "a" is tri-state idle with an 8-bit
//                counter, "b" is hold-last idle with a 2-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_driver_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_ena;
    logic           clr_err;

    wire  [W-1:0]   bus_out_a;
    logic [N-1:0]   grant_a;
    logic           contention_a;
    logic [W-1:0]   bus_q_a;
    logic           valid_a;
    logic [N-1:0]   grant_q_a;
    logic           sticky_a;
    logic [7:0]     cnt_a;

    wire  [W-1:0]   bus_out_b;
    logic [N-1:0]   grant_b;
    logic           contention_b;
    logic [W-1:0]   bus_q_b;
    logic           valid_b;
    logic [N-1:0]   grant_q_b;
    logic           sticky_b;
    logic [1:0]     cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the spec says the registered side should hold.
    logic [W-1:0] m_last;
    logic         m_valid;
    logic [N-1:0] m_grant_q;
    logic         m_sticky;
    int           m_cnt_a;
    int           m_cnt_b;

    logic [W-1:0] c_z;

    always #5 clk = ~clk;

    bus_driver_arbiter #(.WIDTH(W), .NSRC(N), .HOLD_LAST(0), .CNT_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .src_data(src_data), .src_ena(src_ena),
        .clr_err(clr_err), .bus_out(bus_out_a), .grant(grant_a),
        .contention(contention_a), .bus_q(bus_q_a), .bus_q_valid(valid_a),
        .grant_q(grant_q_a), .contention_sticky(sticky_a), .contention_cnt(cnt_a)
    );

    bus_driver_arbiter #(.WIDTH(W), .NSRC(N), .HOLD_LAST(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .src_data(src_data), .src_ena(src_ena),
        .clr_err(clr_err), .bus_out(bus_out_b), .grant(grant_b),
        .contention(contention_b), .bus_q(bus_q_b), .bus_q_valid(valid_b),
        .grant_q(grant_q_b), .contention_sticky(sticky_b), .contention_cnt(cnt_b)
    );

    function automatic logic [N-1:0] ref_grant(input logic [N-1:0] ena);
        logic [N-1:0] g;
        g = '0;
        for (int i = 0; i < N; i++) begin
            if (ena[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [W-1:0] ref_word(input logic [N-1:0] ena, input logic [N*W-1:0] data);
        for (int i = 0; i < N; i++) begin
            if (ena[i]) return data[i*W +: W];
        end
        return '0;
    endfunction

    task automatic set_src(input int idx, input logic [W-1:0] v);
        src_data[idx*W +: W] = v;
    endtask

    task automatic model_reset();
        m_last    = '0;
        m_valid   = 1'b0;
        m_grant_q = '0;
        m_sticky  = 1'b0;
        m_cnt_a   = 0;
        m_cnt_b   = 0;
    endtask

    // Advance one rising edge and apply the spec rules to the reference state.
    task automatic tick();
        logic c;
        @(posedge clk);
        if (reset_n) begin
            c = ($countones(src_ena) > 1);
            if (src_ena != '0) m_last = ref_word(src_ena, src_data);
            m_valid   = (src_ena != '0);
            m_grant_q = ref_grant(src_ena);
            if (c) m_sticky = 1'b1;
            else if (clr_err) m_sticky = 1'b0;
            if (clr_err) begin
                m_cnt_a = c ? 1 : 0;
                m_cnt_b = c ? 1 : 0;
            end else if (c) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3) m_cnt_b++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        src_ena  = '0;
        src_data = '0;
        clr_err  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        n_tests++; if (bus_out_a !== c_z) begin n_fail++; $display("FAIL reset_bus_out_a: got %h, expected %h", bus_out_a, c_z); end
        n_tests++; if (bus_out_b !== 16'h0000) begin n_fail++; $display("FAIL reset_bus_out_b: got %h, expected 0000", bus_out_b); end
        n_tests++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b, expected 0000", grant_a); end
        n_tests++; if (bus_q_a !== 16'h0000) begin n_fail++; $display("FAIL reset_bus_q: got %h, expected 0000", bus_q_a); end
        n_tests++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", valid_a); end
        n_tests++; if (cnt_a !== 8'd0 || sticky_a !== 1'b0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%b, expected 0/0", cnt_a, sticky_a); end
    endtask

    task automatic test_single_driver();
        set_src(1, 16'h3000);
        set_src(2, 16'h1234);
        src_ena = 4'b0010;
        #1;
        n_tests++; if (bus_out_a !== 16'h3000 || grant_a !== 4'b0010) begin n_fail++; $display("FAIL single_pc_comb: got %h/%b, expected 3000/0010", bus_out_a, grant_a); end
        tick();
        n_tests++; if (bus_q_a !== 16'h3000 || grant_q_a !== 4'b0010 || valid_a !== 1'b1) begin n_fail++; $display("FAIL single_pc_reg: got %h/%b/%b, expected 3000/0010/1", bus_q_a, grant_q_a, valid_a); end
        src_ena = 4'b0100;
        #1;
        n_tests++; if (bus_out_a !== 16'h1234 || grant_a !== 4'b0100) begin n_fail++; $display("FAIL single_alu_comb: got %h/%b, expected 1234/0100", bus_out_a, grant_a); end
        tick();
        n_tests++; if (bus_q_a !== 16'h1234 || grant_q_a !== 4'b0100 || valid_a !== 1'b1) begin n_fail++; $display("FAIL single_alu_reg: got %h/%b/%b, expected 1234/0100/1", bus_q_a, grant_q_a, valid_a); end
    endtask

    task automatic test_contention();
        set_src(0, 16'hAAAA);
        set_src(3, 16'h5555);
        src_ena = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (bus_out_a !== 16'hAAAA || grant_a !== 4'b0001 || contention_a !== 1'b1) begin n_fail++; $display("FAIL contention_comb[%0d]: got %h/%b/%b, expected AAAA/0001/1", k, bus_out_a, grant_a, contention_a); end
            tick();
        end
        n_tests++; if (sticky_a !== 1'b1 || cnt_a !== 8'd3) begin n_fail++; $display("FAIL contention_cnt: got %b/%0d, expected 1/3", sticky_a, cnt_a); end
        n_tests++; if (cnt_b !== 2'd3) begin n_fail++; $display("FAIL contention_cnt_b: got %0d, expected 3", cnt_b); end
    endtask

    task automatic test_saturation_clear();
        repeat (5) tick();
        n_tests++; if (cnt_b !== 2'd3) begin n_fail++; $display("FAIL saturate_b: got %0d, expected 3", cnt_b); end
        n_tests++; if (cnt_a !== 8'd8) begin n_fail++; $display("FAIL count_a: got %0d, expected 8", cnt_a); end
        clr_err = 1'b1;
        tick();
        n_tests++; if (cnt_a !== 8'd1 || cnt_b !== 2'd1 || sticky_a !== 1'b1) begin n_fail++; $display("FAIL clear_with_contention: got %0d/%0d/%b, expected 1/1/1", cnt_a, cnt_b, sticky_a); end
        src_ena = 4'b0001;
        tick();
        n_tests++; if (cnt_a !== 8'd0 || cnt_b !== 2'd0 || sticky_a !== 1'b0 || sticky_b !== 1'b0) begin n_fail++; $display("FAIL clear_plain: got %0d/%0d/%b/%b, expected 0/0/0/0", cnt_a, cnt_b, sticky_a, sticky_b); end
        clr_err = 1'b0;
    endtask

    task automatic test_hold();
        set_src(3, 16'hBEEF);
        src_ena = 4'b1000;
        tick();
        src_ena = 4'b0000;
        #1;
        n_tests++; if (bus_out_b !== 16'hBEEF || bus_out_a !== c_z) begin n_fail++; $display("FAIL hold_idle_comb: got %h/%h, expected BEEF/%h", bus_out_b, bus_out_a, c_z); end
        tick();
        n_tests++; if (bus_out_b !== 16'hBEEF || bus_q_b !== 16'hBEEF || valid_b !== 1'b0) begin n_fail++; $display("FAIL hold_idle_reg: got %h/%h/%b, expected BEEF/BEEF/0", bus_out_b, bus_q_b, valid_b); end
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (bus_out_b !== 16'h0000 || bus_q_b !== 16'h0000) begin n_fail++; $display("FAIL hold_async_reset: got %h/%h, expected 0000/0000", bus_out_b, bus_q_b); end
        model_reset();
        #1 reset_n = 1'b1;
    endtask

    task automatic test_async_reset_mid_transfer();
        set_src(1, 16'h2468);
        set_src(2, 16'h1357);
        src_ena = 4'b0110;
        tick();
        src_ena = 4'b0100;
        tick();
        n_tests++; if (bus_q_a !== 16'h1357 || grant_q_a !== 4'b0100 || cnt_a !== 8'd1) begin n_fail++; $display("FAIL pre_reset: got %h/%b/%0d, expected 1357/0100/1", bus_q_a, grant_q_a, cnt_a); end
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (bus_q_a !== 16'h0000 || grant_q_a !== 4'b0000 || valid_a !== 1'b0 || cnt_a !== 8'd0 || sticky_a !== 1'b0) begin n_fail++; $display("FAIL async_reset: got %h/%b/%b/%0d/%b, expected 0000/0000/0/0/0", bus_q_a, grant_q_a, valid_a, cnt_a, sticky_a); end
        n_tests++; if (bus_out_a !== 16'h1357 || grant_a !== 4'b0100) begin n_fail++; $display("FAIL comb_in_reset: got %h/%b, expected 1357/0100", bus_out_a, grant_a); end
        model_reset();
        #1 reset_n = 1'b1;
        tick();
        n_tests++; if (bus_q_a !== 16'h1357 || valid_a !== 1'b1 || grant_q_a !== 4'b0100) begin n_fail++; $display("FAIL post_reset_reload: got %h/%b/%b, expected 1357/1/0100", bus_q_a, valid_a, grant_q_a); end
    endtask

    task automatic test_random();
        logic [W-1:0] e_bus;
        logic [N-1:0] e_grant;
        logic         e_cont;
        for (int k = 0; k < 400; k++) begin
            src_ena  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            src_data = {$urandom, $urandom};
            clr_err  = ($urandom_range(0, 7) == 0);
            #1;
            e_grant = ref_grant(src_ena);
            e_cont  = ($countones(src_ena) > 1);
            e_bus   = ref_word(src_ena, src_data);
            n_tests++; if (grant_a !== e_grant || grant_b !== e_grant) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %b/%b, expected %b", k, grant_a, grant_b, e_grant); end
            n_tests++; if (contention_a !== e_cont || contention_b !== e_cont) begin n_fail++; $display("FAIL rnd_contention[%0d]: got %b/%b, expected %b", k, contention_a, contention_b, e_cont); end
            n_tests++; if (bus_out_a !== ((src_ena != '0) ? e_bus : c_z)) begin n_fail++; $display("FAIL rnd_bus_out_a[%0d]: got %h, expected %h", k, bus_out_a, (src_ena != '0) ? e_bus : c_z); end
            n_tests++; if (bus_out_b !== ((src_ena != '0) ? e_bus : m_last)) begin n_fail++; $display("FAIL rnd_bus_out_b[%0d]: got %h, expected %h", k, bus_out_b, (src_ena != '0) ? e_bus : m_last); end
            tick();
            n_tests++; if (bus_q_a !== m_last || bus_q_b !== m_last) begin n_fail++; $display("FAIL rnd_bus_q[%0d]: got %h/%h, expected %h", k, bus_q_a, bus_q_b, m_last); end
            n_tests++; if (valid_a !== m_valid || grant_q_a !== m_grant_q) begin n_fail++; $display("FAIL rnd_valid_grant_q[%0d]: got %b/%b, expected %b/%b", k, valid_a, grant_q_a, m_valid, m_grant_q); end
            n_tests++; if (sticky_a !== m_sticky || sticky_b !== m_sticky) begin n_fail++; $display("FAIL rnd_sticky[%0d]: got %b/%b, expected %b", k, sticky_a, sticky_b, m_sticky); end
            n_tests++; if (cnt_a !== 8'(m_cnt_a) || cnt_b !== 2'(m_cnt_b)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d, expected %0d/%0d", k, cnt_a, cnt_b, m_cnt_a, m_cnt_b); end
        end
        clr_err = 1'b0;
    endtask

    initial begin
        c_z = 'z;
        test_reset();
        test_single_driver();
        test_contention();
        test_saturation_clear();
        test_hold();
        test_async_reset_mid_transfer();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
